// File: rtl/taxi_qsfp_port_mgr_if.sv
// Per-port QSFP cage signal bundle between the board pins/software side and the port manager.
// All vectors are indexed by port number; port_state carries each port's FSM state (2 bits per port).
interface taxi_qsfp_port_mgr_if #(
    parameter int PORT_CNT = 15
);
    logic [PORT_CNT-1:0]   port_modprsl;
    logic [PORT_CNT-1:0]   port_intl;
    logic [PORT_CNT-1:0]   port_reset_req;
    logic [PORT_CNT-1:0]   port_int_clear;
    logic [PORT_CNT-1:0]   port_resetl;
    logic [PORT_CNT-1:0]   port_lpmode;
    logic [PORT_CNT-1:0]   port_gt_rst;
    logic [PORT_CNT-1:0]   port_present;
    logic [PORT_CNT-1:0]   port_ready;
    logic [PORT_CNT-1:0]   port_int;
    logic [2*PORT_CNT-1:0] port_state;

    // Strobes (reset_req, int_clear) are single-cycle pulses with no back-pressure:
    // the manager acts on every cycle a strobe bit is high, so no ready/ack is returned.
    modport master (
        output port_modprsl, port_intl, port_reset_req, port_int_clear,
        input  port_resetl, port_lpmode, port_gt_rst, port_present, port_ready, port_int, port_state
    );

    modport slave (
        input  port_modprsl, port_intl, port_reset_req, port_int_clear,
        output port_resetl, port_lpmode, port_gt_rst, port_present, port_ready, port_int, port_state
    );
endinterface

// File: rtl/taxi_qsfp_port_mgr.sv
// QSFP28 cage manager: per-port presence debounce, ResetL/LPMode sequencing, transceiver reset
// gating on PLL lock, and latched IntL events. Every port runs an independent copy of the logic.
module taxi_qsfp_port_mgr #(
    parameter int PORT_CNT     = 15,
    parameter int DEB_CYCLES   = 125000,
    parameter int RESET_CYCLES = 1250,
    parameter int INIT_CYCLES  = 250000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pll_locked,
    taxi_qsfp_port_mgr_if.slave  bus
);

    localparam int CNT_MAX = (RESET_CYCLES > INIT_CYCLES) ? RESET_CYCLES : INIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] INIT_LOAD  = CNT_W'(INIT_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);

    if (PORT_CNT < 1 || DEB_CYCLES < 1 || RESET_CYCLES < 1 || INIT_CYCLES < 1) begin : g_param_chk
        $error("taxi_qsfp_port_mgr: PORT_CNT and all cycle parameters must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_ABSENT = 2'd0,
        ST_RESET  = 2'd1,
        ST_INIT   = 2'd2,
        ST_READY  = 2'd3
    } state_e;

    // 2-FF synchronisers; reset to the idle pin levels (absent, no interrupt, unlocked)
    logic [PORT_CNT-1:0] prs_s1_q, prs_s2_q;
    logic [PORT_CNT-1:0] intl_s1_q, intl_s2_q, intl_prev_q;
    logic                pll_s1_q, pll_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prs_s1_q    <= '1;
            prs_s2_q    <= '1;
            intl_s1_q   <= '1;
            intl_s2_q   <= '1;
            intl_prev_q <= '1;
            pll_s1_q    <= 1'b0;
            pll_s2_q    <= 1'b0;
        end else begin
            prs_s1_q    <= bus.port_modprsl;
            prs_s2_q    <= prs_s1_q;
            intl_s1_q   <= bus.port_intl;
            intl_s2_q   <= intl_s1_q;
            intl_prev_q <= intl_s2_q;
            pll_s1_q    <= pll_locked;
            pll_s2_q    <= pll_s1_q;
        end
    end

    for (genvar i = 0; i < PORT_CNT; i++) begin : g_port
        logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
        logic             present_q, present_d;
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             resetl_q, resetl_d;
        logic             lpmode_q, lpmode_d;
        logic             gt_rst_q, gt_rst_d;
        logic             ready_q, ready_d;
        logic             int_q, int_d;
        logic             int_fall;

        always_comb begin
            deb_cnt_d = deb_cnt_q;
            present_d = present_q;
            if (~prs_s2_q[i] == present_q) begin
                deb_cnt_d = '0;
            end else if (deb_cnt_q == DEB_LAST) begin
                present_d = ~present_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end

        // Loss of presence beats a reset request, which beats counter expiry
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            if (!present_q) begin
                state_d = ST_ABSENT;
            end else if (bus.port_reset_req[i] && state_q != ST_ABSENT) begin
                state_d = ST_RESET;
                cnt_d   = RESET_LOAD;
            end else begin
                case (state_q)
                    ST_ABSENT: begin
                        state_d = ST_RESET;
                        cnt_d   = RESET_LOAD;
                    end
                    ST_RESET: begin
                        if (cnt_q == '0) begin
                            state_d = ST_INIT;
                            cnt_d   = INIT_LOAD;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    ST_INIT: begin
                        if (cnt_q == '0) begin
                            state_d = ST_READY;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign int_fall = intl_prev_q[i] & ~intl_s2_q[i];

        always_comb begin
            resetl_d = 1'b0;
            lpmode_d = 1'b1;
            gt_rst_d = 1'b1;
            ready_d  = 1'b0;
            case (state_q)
                ST_INIT: begin
                    resetl_d = 1'b1;
                    lpmode_d = 1'b0;
                end
                ST_READY: begin
                    resetl_d = 1'b1;
                    lpmode_d = 1'b0;
                    ready_d  = 1'b1;
                    gt_rst_d = ~pll_s2_q;
                end
                default: ;
            endcase
            int_d = int_q;
            if (bus.port_int_clear[i] || state_q == ST_ABSENT) begin
                int_d = 1'b0;
            end
            if (int_fall && state_q == ST_READY) begin
                int_d = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                deb_cnt_q <= '0;
                present_q <= 1'b0;
                state_q   <= ST_ABSENT;
                cnt_q     <= '0;
                resetl_q  <= 1'b0;
                lpmode_q  <= 1'b1;
                gt_rst_q  <= 1'b1;
                ready_q   <= 1'b0;
                int_q     <= 1'b0;
            end else begin
                deb_cnt_q <= deb_cnt_d;
                present_q <= present_d;
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                resetl_q  <= resetl_d;
                lpmode_q  <= lpmode_d;
                gt_rst_q  <= gt_rst_d;
                ready_q   <= ready_d;
                int_q     <= int_d;
            end
        end

        assign bus.port_resetl[i]        = resetl_q;
        assign bus.port_lpmode[i]        = lpmode_q;
        assign bus.port_gt_rst[i]        = gt_rst_q;
        assign bus.port_present[i]       = present_q;
        assign bus.port_ready[i]         = ready_q;
        assign bus.port_int[i]           = int_q;
        assign bus.port_state[2*i +: 2]  = state_q;
    end

endmodule

// File: tb/tb_taxi_qsfp_port_mgr.sv
// Directed bench for taxi_qsfp_port_mgr with 2 ports and short cycle parameters.
// Inputs change and outputs are checked on the falling clock edge; times are counted from reset release.
module tb_taxi_qsfp_port_mgr;

  localparam int W = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic pll_locked;
  int   n_vec = 0;
  int   n_err = 0;

  logic [W-1:0] exp_q[$];

  taxi_qsfp_port_mgr_if #(.PORT_CNT(2)) bus ();

  taxi_qsfp_port_mgr #(
    .PORT_CNT    (2),
    .DEB_CYCLES  (4),
    .RESET_CYCLES(8),
    .INIT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    logic [W-1:0] e;
    n_vec++;
    exp_q.push_back(exp);
    e = exp_q.pop_front();
    if (obs !== e) begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
    end
  endtask

  initial begin
    rst                = 1'b1;
    pll_locked         = 1'b1;
    bus.port_modprsl   = 2'b10;
    bus.port_intl      = 2'b11;
    bus.port_reset_req = 2'b00;
    bus.port_int_clear = 2'b00;
    step(3);
    check("rst_resetl",  bus.port_resetl,  2'b00);
    check("rst_lpmode",  bus.port_lpmode,  2'b11);
    check("rst_gt_rst",  bus.port_gt_rst,  2'b11);
    check("rst_present", bus.port_present, 2'b00);
    check("rst_ready",   bus.port_ready,   2'b00);
    check("rst_int",     bus.port_int,     2'b00);
    check("rst_state",   bus.port_state,   4'h0);
    rst = 1'b0;                                                  // t=0
    step(1); bus.port_modprsl = 2'b00;                           // t=1: 3-cycle glitch on port 1
    step(3); bus.port_modprsl = 2'b10;                           // t=4
    step(1); check("deb_p0_early", bus.port_present[0], 1'b0);   // t=5
    step(1); check("deb_p0_set",   bus.port_present[0], 1'b1);   // t=6
    step(1); check("p0_in_reset",  bus.port_state[1:0], 2'd1);   // t=7
    step(3);                                                     // t=10
    check("glitch_present1", bus.port_present[1], 1'b0);
    check("glitch_resetl1",  bus.port_resetl[1],  1'b0);
    check("glitch_lpmode1",  bus.port_lpmode[1],  1'b1);
    check("glitch_state1",   bus.port_state[3:2], 2'd0);
    step(5); check("pwr_resetl_low", bus.port_resetl[0], 1'b0);  // t=15
    step(1);                                                     // t=16
    check("pwr_resetl_rise", bus.port_resetl[0], 1'b1);
    check("pwr_lpmode_fall", bus.port_lpmode[0], 1'b0);
    step(15);                                                    // t=31
    check("init_not_ready", bus.port_ready[0],  1'b0);
    check("init_gt_rst",    bus.port_gt_rst[0], 1'b1);
    step(1);                                                     // t=32
    check("ready_set",    bus.port_ready[0],  1'b1);
    check("ready_gt_rel", bus.port_gt_rst[0], 1'b0);
    // PLL lock loss in READY
    pll_locked = 1'b0;
    step(2); check("pll_gt_hold", bus.port_gt_rst[0], 1'b0);     // t=34
    step(1);                                                     // t=35
    check("pll_gt_assert", bus.port_gt_rst[0], 1'b1);
    check("pll_ready",     bus.port_ready[0],  1'b1);
    pll_locked = 1'b1;
    step(3); check("pll_relock", bus.port_gt_rst[0], 1'b0);      // t=38
    // IntL falling edge in READY
    bus.port_intl = 2'b10;
    step(2); check("int_early", bus.port_int[0], 1'b0);          // t=40
    step(1); check("int_set",   bus.port_int[0], 1'b1);          // t=41
    bus.port_intl      = 2'b11;
    bus.port_int_clear = 2'b01;
    step(1); check("int_clear", bus.port_int[0], 1'b0);          // t=42
    bus.port_int_clear = 2'b00;
    step(2); bus.port_intl = 2'b10;                              // t=44
    step(2); bus.port_int_clear = 2'b01;                         // t=46
    step(1); check("int_set_wins", bus.port_int[0], 1'b1);       // t=47
    step(1); check("int_clear2",   bus.port_int[0], 1'b0);       // t=48
    bus.port_int_clear = 2'b00;
    // Software reset in READY, restarted 3 cycles into RESET
    bus.port_reset_req = 2'b01;
    step(1);                                                     // t=49
    bus.port_reset_req = 2'b00;
    check("req_out_lag", bus.port_resetl[0], 1'b1);
    step(1);                                                     // t=50
    check("req_resetl", bus.port_resetl[0], 1'b0);
    check("req_ready",  bus.port_ready[0],  1'b0);
    step(1); bus.port_reset_req = 2'b01;                         // t=51
    step(1); bus.port_reset_req = 2'b00;                         // t=52
    step(6); check("req2_restart",   bus.port_resetl[0], 1'b0);  // t=58
    step(2); check("req2_low_end",   bus.port_resetl[0], 1'b0);  // t=60
    step(1); check("req2_resetl_up", bus.port_resetl[0], 1'b1);  // t=61
    // IntL edge during INIT is ignored
    bus.port_intl = 2'b11;
    step(3); bus.port_intl = 2'b10;                              // t=64
    step(4); check("int_in_init", bus.port_int[0], 1'b0);        // t=68
    // Removal during INIT
    bus.port_modprsl = 2'b11;
    step(5); check("rm_present_hold", bus.port_present[0], 1'b1); // t=73
    step(1); check("rm_present_clr",  bus.port_present[0], 1'b0); // t=74
    step(2);                                                     // t=76
    check("rm_resetl", bus.port_resetl[0], 1'b0);
    check("rm_lpmode", bus.port_lpmode[0], 1'b1);
    check("rm_ready",  bus.port_ready[0],  1'b0);
    check("rm_gt_rst", bus.port_gt_rst[0], 1'b1);
    check("rm_state",  bus.port_state,     4'h0);
    // Reinsert, then assert rst asynchronously mid-sequence
    bus.port_modprsl = 2'b10;
    bus.port_intl    = 2'b11;
    step(10);
    check("reins_state", bus.port_state[1:0], 2'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_present", bus.port_present, 2'b00);
    check("arst_resetl",  bus.port_resetl,  2'b00);
    check("arst_state",   bus.port_state,   4'h0);
    step(2);
    rst = 1'b0;
    step(5); check("redeb_early", bus.port_present[0], 1'b0);
    step(1); check("redeb_set",   bus.port_present[0], 1'b1);
    check("p1_untouched", bus.port_present[1], 1'b0);
    // final report
    if (exp_q.size() != 0) begin
      n_err++;
      $error("FAIL scoreboard: %0d expectations left unchecked", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    if (n_err == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule
